// File: rtl/ps2_kbd_ascii.sv
// PS/2 keyboard receiver with scan-code set 2 make/break decoding to an ASCII "held key" bus.
// Also provides the last raw byte, a new-key strobe and a sticky framing-error flag.
module ps2_kbd_ascii #(
    parameter int TIMEOUT     = 50000,
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] kbdata,
    output logic       key_pulse,
    output logic [7:0] scan_code,
    output logic       frame_err
);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TO_MAX = TW'(TIMEOUT - 1);
    localparam logic [TW-1:0] TO_ONE = TW'(1);

    typedef enum logic [1:0] {IDLE, SHIFT, PARITY, STOP} rx_state_t;

    rx_state_t              state_q;
    logic [SYNC_STAGES-1:0] clk_sync_q;
    logic [SYNC_STAGES-1:0] data_sync_q;
    logic                   clk_prev_q;
    logic [3:0]             n_q;
    logic [7:0]             shift_q;
    logic                   par_q;
    logic [TW-1:0]          to_cnt_q;
    logic                   err_q;
    logic [7:0]             kbdata_q, kbdata_d;
    logic                   key_pulse_q, key_pulse_d;
    logic [7:0]             scan_code_q, scan_code_d;
    logic                   brk_q, brk_d;
    logic                   ext_q, ext_d;
    logic                   clk_s, data_s, fall_s, par_ok_s, accept_s;
    logic [7:0]             mapped_s;

    function automatic logic [7:0] scan_to_ascii(input logic [7:0] sc);
        case (sc)
            8'h1C: scan_to_ascii = 8'h41;  8'h32: scan_to_ascii = 8'h42;
            8'h21: scan_to_ascii = 8'h43;  8'h23: scan_to_ascii = 8'h44;
            8'h24: scan_to_ascii = 8'h45;  8'h2B: scan_to_ascii = 8'h46;
            8'h34: scan_to_ascii = 8'h47;  8'h33: scan_to_ascii = 8'h48;
            8'h43: scan_to_ascii = 8'h49;  8'h3B: scan_to_ascii = 8'h4A;
            8'h42: scan_to_ascii = 8'h4B;  8'h4B: scan_to_ascii = 8'h4C;
            8'h3A: scan_to_ascii = 8'h4D;  8'h31: scan_to_ascii = 8'h4E;
            8'h44: scan_to_ascii = 8'h4F;  8'h4D: scan_to_ascii = 8'h50;
            8'h15: scan_to_ascii = 8'h51;  8'h2D: scan_to_ascii = 8'h52;
            8'h1B: scan_to_ascii = 8'h53;  8'h2C: scan_to_ascii = 8'h54;
            8'h3C: scan_to_ascii = 8'h55;  8'h2A: scan_to_ascii = 8'h56;
            8'h1D: scan_to_ascii = 8'h57;  8'h22: scan_to_ascii = 8'h58;
            8'h35: scan_to_ascii = 8'h59;  8'h1A: scan_to_ascii = 8'h5A;
            8'h45: scan_to_ascii = 8'h30;  8'h16: scan_to_ascii = 8'h31;
            8'h1E: scan_to_ascii = 8'h32;  8'h26: scan_to_ascii = 8'h33;
            8'h25: scan_to_ascii = 8'h34;  8'h2E: scan_to_ascii = 8'h35;
            8'h36: scan_to_ascii = 8'h36;  8'h3D: scan_to_ascii = 8'h37;
            8'h3E: scan_to_ascii = 8'h38;  8'h46: scan_to_ascii = 8'h39;
            8'h29: scan_to_ascii = 8'h20;  8'h5A: scan_to_ascii = 8'h0D;
            default: scan_to_ascii = 8'h00;
        endcase
    endfunction

    assign clk_s    = clk_sync_q[SYNC_STAGES-1];
    assign data_s   = data_sync_q[SYNC_STAGES-1];
    assign fall_s   = clk_prev_q & ~clk_s;
    assign par_ok_s = ^{shift_q, par_q};
    assign accept_s = fall_s && (state_q == STOP) && data_s && par_ok_s;

    // Input synchronisers, frame receiver FSM, idle timeout and sticky error flag.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            clk_sync_q  <= {SYNC_STAGES{1'b1}};
            data_sync_q <= {SYNC_STAGES{1'b1}};
            clk_prev_q  <= 1'b1;
            state_q     <= IDLE;
            n_q         <= 4'd0;
            shift_q     <= 8'h00;
            par_q       <= 1'b0;
            to_cnt_q    <= '0;
            err_q       <= 1'b0;
        end else begin
            clk_sync_q  <= {clk_sync_q[SYNC_STAGES-2:0], ps2_clk};
            data_sync_q <= {data_sync_q[SYNC_STAGES-2:0], ps2_data};
            clk_prev_q  <= clk_s;
            if (fall_s) begin
                to_cnt_q <= '0;
                case (state_q)
                    IDLE: begin
                        if (!data_s) begin
                            state_q <= SHIFT;
                            n_q     <= 4'd0;
                        end else begin
                            err_q   <= 1'b1;
                        end
                    end
                    SHIFT: begin
                        shift_q <= {data_s, shift_q[7:1]};
                        n_q     <= n_q + 4'd1;
                        if (n_q == 4'd7) begin
                            state_q <= PARITY;
                        end
                    end
                    PARITY: begin
                        par_q   <= data_s;
                        state_q <= STOP;
                    end
                    STOP: begin
                        if (!(data_s && par_ok_s)) begin
                            err_q <= 1'b1;
                        end
                        state_q <= IDLE;
                    end
                    default: state_q <= IDLE;
                endcase
            end else if (state_q != IDLE) begin
                // A stalled partial frame is dropped silently; the error flag is left alone.
                if (to_cnt_q == TO_MAX) begin
                    state_q  <= IDLE;
                    to_cnt_q <= '0;
                end else begin
                    to_cnt_q <= to_cnt_q + TO_ONE;
                end
            end else begin
                to_cnt_q <= '0;
            end
        end
    end

    // Make/break decoder; extended-prefixed keys map to 0 but still consume the flags.
    always_comb begin
        kbdata_d    = kbdata_q;
        key_pulse_d = 1'b0;
        scan_code_d = scan_code_q;
        brk_d       = brk_q;
        ext_d       = ext_q;
        mapped_s    = ext_q ? 8'h00 : scan_to_ascii(shift_q);
        if (accept_s) begin
            scan_code_d = shift_q;
            if (shift_q == 8'hF0) begin
                brk_d = 1'b1;
            end else if (shift_q == 8'hE0) begin
                ext_d = 1'b1;
            end else begin
                if (brk_q) begin
                    if (mapped_s == kbdata_q) begin
                        kbdata_d = 8'h00;
                    end else begin
                        kbdata_d = kbdata_q;
                    end
                end else begin
                    kbdata_d    = mapped_s;
                    key_pulse_d = (mapped_s != 8'h00);
                end
                brk_d = 1'b0;
                ext_d = 1'b0;
            end
        end else begin
            kbdata_d = kbdata_q;
        end
    end

    // Decoder state and registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            kbdata_q    <= 8'h00;
            key_pulse_q <= 1'b0;
            scan_code_q <= 8'h00;
            brk_q       <= 1'b0;
            ext_q       <= 1'b0;
        end else begin
            kbdata_q    <= kbdata_d;
            key_pulse_q <= key_pulse_d;
            scan_code_q <= scan_code_d;
            brk_q       <= brk_d;
            ext_q       <= ext_d;
        end
    end

    assign kbdata    = kbdata_q;
    assign key_pulse = key_pulse_q;
    assign scan_code = scan_code_q;
    assign frame_err = err_q;

endmodule
